multi_mode_vco: RTL and testbench
=================================

MULTI_MODE_VCO -- requirements
Module: multi_mode_vco

Interface
REQ-001 SHALL have parameter VIN_W, default 10: control-voltage width (unsigned).
REQ-002 SHALL have parameter GAIN_W, default 8: gain word width.
REQ-003 SHALL have parameter ACC_W, default 16: phase accumulator width.
REQ-004 SHALL have parameter DIV_W, default 4: divider select width.
REQ-005 SHALL have port clk  input  1: clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1: reset, synchronous, active-high.
REQ-007 SHALL have port en  input  1: advance enable; low freezes all state.
REQ-008 SHALL have port input_voltage_real  input  VIN_W: control voltage.
REQ-009 SHALL have port gain  input  GAIN_W: tuning gain, unsigned Q0.GAIN_W.
REQ-010 SHALL have port offset  input  ACC_W: free-running base increment.
REQ-011 SHALL have port div_sel  input  DIV_W: divided-clock half-period in rise events, minus 1.
REQ-012 SHALL have port output_clock_digital  output  1: phase MSB.
REQ-013 SHALL have port output_clock_divided  output  1: divided clock.
REQ-014 SHALL have port rise_pulse  output  1: one-cycle pulse per output_clock_digital rising edge.
REQ-015 SHALL have port sat  output  1: increment clamped this cycle.
REQ-016 SHALL have port phase  output  ACC_W: accumulator value.

Function
REQ-017 SHALL register input_voltage_real into vin_q on each edge with en=1.
REQ-018 SHALL compute prod = vin_q*gain at full VIN_W+GAIN_W width, then raw = offset + (prod >> GAIN_W) at ACC_W+1 bits, with no truncation before the clamp.
REQ-019 SHALL clamp raw to FMAX = 2^(ACC_W-2) and register the result into inc_q, so the output always has at least 4 samples per period.
REQ-020 SHALL register sat alongside inc_q: sat=1 when raw > FMAX, else 0.
REQ-021 SHALL update phase <= (phase + inc_q) mod 2^ACC_W on each edge with en=1; wrap-around is silent.
REQ-022 SHALL give a control latency of 2 edges: input change at edge t is first reflected in the phase update at edge t+2.
REQ-023 SHALL drive output_clock_digital = phase[ACC_W-1] directly from the register, with no combinational path from any input.
REQ-024 SHALL keep an msb_d register; rise_pulse=1 for exactly one cycle after an edge where the MSB goes 0->1.
REQ-025 SHALL count rise events; when count == div_sel on a rise, output_clock_divided toggles and count clears; otherwise count increments.
REQ-026 SHALL treat a rise with count > div_sel (div_sel lowered mid-run) as a match: toggle and clear.
REQ-027 SHALL freeze vin_q, inc_q, sat, phase, msb_d, count and the divided clock while en=0, with rise_pulse forced to 0; operation resumes seamlessly on the next en=1 edge.
REQ-028 SHALL treat offset=0 with gain=0 as a legal stopped oscillator: phase constant, no pulses.

Reset
REQ-029 SHALL on reset=1 clear vin_q, inc_q, sat, phase, msb_d and count to 0, and drive output_clock_divided and rise_pulse to 0; reset overrides en.
REQ-030 SHALL allow reset mid-operation to take effect at that edge with no residual pulse on the following cycle.

Structure
REQ-031 SHALL place default widths and the FMAX constant function in shared package vco_pkg.
REQ-032 SHALL implement the rise counter and toggle (REQ-025/026) as sub-module edge_clock_divider, parametrised by DIV_W.

Verification
REQ-033 SHALL test: offset=4096, gain=0, en=1 -> phase steps by 4096; output_clock_digital period 16 cycles; rise_pulse every 16 cycles; sat=0.
REQ-034 SHALL test: offset=0, gain=255, vin=1023 -> inc_q=1019 two edges after vin is applied; phase advances by 1019 per cycle.
REQ-035 SHALL test: offset=20000 -> inc_q=16384, sat=1, output period 4 cycles (2 high, 2 low).
REQ-036 SHALL test: offset=4096, div_sel=1 -> output_clock_divided period 64 cycles; then div_sel 3->0 mid-count -> toggle on the next rise.
REQ-037 SHALL test: en low for 10 cycles mid-period -> phase, outputs and count hold, rise_pulse=0; en high resumes from the held phase.
REQ-038 SHALL test: reset asserted one cycle after a rise_pulse -> all outputs 0 on the next cycle; the restart from phase 0 reproduces the REQ-033 waveform.

Source files
------------

// File: rtl/vco_pkg.sv
// -----------------------------------------------------------------------------
// vco_pkg
// Shared defaults for the multi-mode VCO slice.
//   VIN_W_DEF / GAIN_W_DEF / ACC_W_DEF / DIV_W_DEF : default parameter widths
//   fmax_of(acc_w) : largest phase increment allowed for an acc_w-bit
//                    accumulator (quarter turn, so at least 4 samples/period)
// -----------------------------------------------------------------------------
package vco_pkg;

  localparam int VIN_W_DEF  = 10;
  localparam int GAIN_W_DEF = 8;
  localparam int ACC_W_DEF  = 16;
  localparam int DIV_W_DEF  = 4;

  // Quarter of the accumulator range: 2^(acc_w-2).
  function automatic logic [31:0] fmax_of(input int acc_w);
    return 32'd1 << (acc_w - 2);
  endfunction

endpackage

// File: rtl/edge_clock_divider.sv
// -----------------------------------------------------------------------------
// edge_clock_divider
// Counts rise events and toggles a divided clock every (div_sel+1) rises.
// Ports:
//   clk, reset     : rising-edge clock, synchronous active-high reset
//   en             : advance enable; low holds count and divided clock
//   rise           : one rise event to be consumed at this edge
//   div_sel        : half-period of div_clk in rise events, minus 1
//   div_clk        : divided clock output (registered)
// -----------------------------------------------------------------------------
module edge_clock_divider
  import vco_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             rise,
  input  logic [DIV_W-1:0] div_sel,
  output logic             div_clk
);

  logic [DIV_W-1:0] count;

  // Rise counter and toggle; ">=" so a div_sel lowered below the running
  // count still matches on the next rise instead of wrapping the counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      div_clk <= 1'b0;
    end else if (en && rise) begin
      if (count >= div_sel) begin
        count   <= '0;
        div_clk <= ~div_clk;
      end else begin
        count   <= count + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/multi_mode_vco.sv
// -----------------------------------------------------------------------------
// multi_mode_vco
// Digital VCO: a phase accumulator whose increment is
//   clamp(offset + ((vin * gain) >> GAIN_W), FMAX)
// with a two-edge control pipeline (vin_q, then inc_q).
// Ports:
//   clk, reset            : rising-edge clock, synchronous active-high reset
//   en                    : advance enable; low freezes all state
//   input_voltage_real    : control voltage (unsigned)
//   gain                  : tuning gain, unsigned Q0.GAIN_W
//   offset                : free-running base increment
//   div_sel               : divided-clock half-period in rises, minus 1
//   output_clock_digital  : phase MSB
//   output_clock_divided  : divided clock
//   rise_pulse            : one cycle per 0->1 of output_clock_digital
//   sat                   : registered increment was clamped
//   phase                 : accumulator value
// -----------------------------------------------------------------------------
module multi_mode_vco
  import vco_pkg::*;
#(
  parameter int VIN_W  = VIN_W_DEF,
  parameter int GAIN_W = GAIN_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [VIN_W-1:0]  input_voltage_real,
  input  logic [GAIN_W-1:0] gain,
  input  logic [ACC_W-1:0]  offset,
  input  logic [DIV_W-1:0]  div_sel,
  output logic              output_clock_digital,
  output logic              output_clock_divided,
  output logic              rise_pulse,
  output logic              sat,
  output logic [ACC_W-1:0]  phase
);

  localparam int PROD_W = VIN_W + GAIN_W;
  localparam int RAW_W  = ACC_W + 1;
  localparam logic [RAW_W-1:0] FMAX = RAW_W'(fmax_of(ACC_W));

  logic [VIN_W-1:0]  vin_q;
  logic [ACC_W-1:0]  inc_q;
  logic              msb_d;
  logic              live;      // last edge was an active (en=1, no reset) edge
  logic [PROD_W-1:0] prod;
  logic [RAW_W-1:0]  raw;
  logic [RAW_W-1:0]  inc_next;
  logic              sat_next;
  logic              rise_evt;

  // Full-width product; one extra bit on the sum so the clamp sees true overflow.
  assign prod = PROD_W'(vin_q) * PROD_W'(gain);
  assign raw  = RAW_W'(offset) + RAW_W'(prod >> GAIN_W);

  // Clamp the raw increment to a quarter turn and flag saturation.
  always_comb begin
    inc_next = raw;
    sat_next = 1'b0;
    if (raw > FMAX) begin
      inc_next = FMAX;
      sat_next = 1'b1;
    end else begin
      inc_next = raw;
      sat_next = 1'b0;
    end
  end

  // Control pipeline, accumulator and MSB history; en=0 holds everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      vin_q <= '0;
      inc_q <= '0;
      sat   <= 1'b0;
      phase <= '0;
      msb_d <= 1'b0;
      live  <= 1'b0;
    end else if (en) begin
      vin_q <= input_voltage_real;
      inc_q <= inc_next[ACC_W-1:0];
      sat   <= sat_next;
      phase <= phase + inc_q;
      msb_d <= phase[ACC_W-1];
      live  <= 1'b1;
    end else begin
      live  <= 1'b0;
    end
  end

  assign output_clock_digital = phase[ACC_W-1];

  // The MSB rose at the last active edge. The flag persists through a freeze,
  // so the divider consumes it on the first active edge afterwards, while
  // "live" keeps the visible pulse to a single cycle.
  assign rise_evt   = phase[ACC_W-1] & ~msb_d;
  assign rise_pulse = rise_evt & live;

  edge_clock_divider #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .rise    (rise_evt),
    .div_sel (div_sel),
    .div_clk (output_clock_divided)
  );

endmodule

// File: tb/tb_multi_mode_vco.sv
// -----------------------------------------------------------------------------
// tb_multi_mode_vco
// Self-checking bench for multi_mode_vco. A behavioural model (plain integer
// arithmetic) is stepped at every clock edge and all outputs are compared
// #1 after the edge. Directed scenarios are followed by randomized stimulus.
// -----------------------------------------------------------------------------
module tb_multi_mode_vco;

  logic        clk;
  logic        reset;
  logic        en;
  logic [9:0]  input_voltage_real;
  logic [7:0]  gain;
  logic [15:0] offset;
  logic [3:0]  div_sel;
  logic        output_clock_digital;
  logic        output_clock_divided;
  logic        rise_pulse;
  logic        sat;
  logic [15:0] phase;

  int n_cmp = 0;
  int n_err = 0;

  // Model state
  int unsigned m_vin   = 0;
  int unsigned m_inc   = 0;
  int unsigned m_phase = 0;
  int unsigned m_cnt   = 0;
  bit          m_sat   = 1'b0;
  bit          m_div   = 1'b0;
  bit          m_pulse = 1'b0;
  bit          m_pend  = 1'b0;   // rise seen, not yet counted by the divider

  multi_mode_vco dut (
    .clk                  (clk),
    .reset                (reset),
    .en                   (en),
    .input_voltage_real   (input_voltage_real),
    .gain                 (gain),
    .offset               (offset),
    .div_sel              (div_sel),
    .output_clock_digital (output_clock_digital),
    .output_clock_divided (output_clock_divided),
    .rise_pulse           (rise_pulse),
    .sat                  (sat),
    .phase                (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply the rules for one clock edge using the inputs currently driven.
  task automatic model_step();
    int unsigned raw;
    int unsigned nph;
    if (reset) begin
      m_vin = 0; m_inc = 0; m_phase = 0; m_cnt = 0;
      m_sat = 1'b0; m_div = 1'b0; m_pulse = 1'b0; m_pend = 1'b0;
    end else if (en) begin
      if (m_pend) begin
        if (m_cnt >= 32'(div_sel)) begin
          m_div = ~m_div;
          m_cnt = 0;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
      raw     = 32'(offset) + (m_vin * 32'(gain)) / 256;
      nph     = (m_phase + m_inc) % 65536;
      m_pulse = (m_phase < 32768) && (nph >= 32768);
      m_pend  = m_pulse;
      m_phase = nph;
      m_inc   = (raw > 16384) ? 16384 : raw;
      m_sat   = (raw > 16384);
      m_vin   = 32'(input_voltage_real);
    end else begin
      m_pulse = 1'b0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_eq("phase",       32'(phase),                32'(m_phase));
    check_eq("clk_digital", 32'(output_clock_digital), 32'(m_phase >= 32768));
    check_eq("clk_divided", 32'(output_clock_divided), 32'(m_div));
    check_eq("rise_pulse",  32'(rise_pulse),           32'(m_pulse));
    check_eq("sat",         32'(sat),                  32'(m_sat));
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      0:       return rise_pulse;
      1:       return output_clock_divided;
      default: return output_clock_digital;
    endcase
  endfunction

  // Tick until the selected output goes 0->1; n = cycles taken.
  task automatic wait_rise(input int sel, input int bound, output int n);
    logic prev;
    logic cur;
    bit   found;
    found = 1'b0;
    n     = 0;
    prev  = pick(sel);
    while (n < bound) begin
      tick();
      n++;
      cur = pick(sel);
      if (cur && !prev) begin
        found = 1'b1;
        break;
      end
      prev = cur;
    end
    check_eq("wait_found", 32'(found), 32'd1);
  endtask

  int          n;
  logic [15:0] p;
  int unsigned held;

  initial begin
    reset = 1'b1; en = 1'b0; input_voltage_real = 10'd0;
    gain = 8'd0; offset = 16'd0; div_sel = 4'd0;
    tick(); tick();
    check_eq("rst_phase", 32'(phase), 32'd0);

    // Free-running at offset 4096: step 4096, period 16
    reset = 1'b0; en = 1'b1; offset = 16'd4096; div_sel = 4'd15;
    repeat (3) tick();
    p = phase;
    tick();
    check_eq("step_4096", 32'(phase - p), 32'd4096);
    wait_rise(0, 40, n);
    wait_rise(0, 40, n);
    check_eq("pulse_period", 32'(n), 32'd16);
    wait_rise(2, 40, n);
    check_eq("digital_period", 32'(n), 32'd16);

    // Gain path: 1023*255 >> 8 = 1019, visible two edges after vin
    reset = 1'b1; tick(); reset = 1'b0;
    offset = 16'd0; gain = 8'd255; input_voltage_real = 10'd1023;
    tick(); tick();
    p = phase;
    tick();
    check_eq("step_1019", 32'(phase - p), 32'd1019);
    p = phase;
    tick();
    check_eq("step_1019b", 32'(phase - p), 32'd1019);

    // Clamp: 20000 -> 16384, period 4
    offset = 16'd20000; gain = 8'd0;
    repeat (4) tick();
    check_eq("sat_hi", 32'(sat), 32'd1);
    wait_rise(2, 20, n);
    wait_rise(2, 20, n);
    check_eq("clamp_period", 32'(n), 32'd4);

    // Divider: div_sel=1 -> period 64
    reset = 1'b1; tick(); reset = 1'b0;
    offset = 16'd4096; div_sel = 4'd1;
    wait_rise(1, 200, n);
    wait_rise(1, 200, n);
    check_eq("div_period", 32'(n), 32'd64);

    // Lower div_sel below a running count -> toggle on the next rise
    div_sel = 4'd3;
    wait_rise(1, 300, n);
    wait_rise(0, 40, n);
    wait_rise(0, 40, n);
    tick();
    div_sel = 4'd0;
    wait_rise(0, 40, n);
    tick();
    check_eq("div_early", 32'(output_clock_divided), 32'd0);

    // Freeze mid-period
    repeat (5) tick();
    held = m_phase;
    en = 1'b0;
    repeat (10) tick();
    check_eq("hold_phase", 32'(phase), held);
    check_eq("hold_pulse", 32'(rise_pulse), 32'd0);
    en = 1'b1;
    repeat (20) tick();

    // Reset right after a pulse, then restart reproduces the 16-cycle waveform
    div_sel = 4'd15;
    wait_rise(0, 40, n);
    reset = 1'b1;
    tick();
    check_eq("rst_pulse", 32'(rise_pulse), 32'd0);
    check_eq("rst_phase2", 32'(phase), 32'd0);
    reset = 1'b0;
    wait_rise(2, 40, n);
    wait_rise(2, 40, n);
    check_eq("restart_period", 32'(n), 32'd16);

    // Randomized operation
    for (int i = 0; i < 800; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      en    = ($urandom_range(0, 9) != 0);
      input_voltage_real = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 15) == 0) begin
        gain    = 8'($urandom_range(0, 255));
        offset  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 65535))
                                               : 16'($urandom_range(0, 8191));
        div_sel = 4'($urandom_range(0, 15));
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
